// File: rtl/aes_serial_selftest.sv
// rtl/aes_serial_selftest.sv - self-test sequencer for the one-bit serial AES encrypt/decrypt cores
module aes_serial_selftest #(
    parameter int NK      = 8,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [127:0]      plaintext,
    input  logic [32*NK-1:0]  key,
    input  logic [127:0]      expected_ct,
    output logic              enc_cs,
    output logic              dec_cs,
    output logic              enc_din,
    output logic              dec_din,
    input  logic              enc_dout,
    input  logic              dec_dout,
    input  logic              enc_finished,
    input  logic              dec_finished,
    output logic              busy,
    output logic              done,
    output logic              pass_enc,
    output logic              pass_dec,
    output logic              err_timeout,
    output logic [127:0]      ct_out,
    output logic [127:0]      pt_out
);

    localparam int KEY_BITS = 32 * NK;
    localparam int FRAME    = 128 + KEY_BITS;
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(FRAME - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(127);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("aes_serial_selftest: NK must be 4, 6 or 8");
    end
    if ((2 ** CNT_W) < FRAME || (2 ** CNT_W) < TIMEOUT) begin : g_bad_cnt_w
        $error("aes_serial_selftest: CNT_W too narrow for FRAME/TIMEOUT");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_ENC_LOAD,
        S_ENC_WAIT,
        S_ENC_READ,
        S_DEC_LOAD,
        S_DEC_WAIT,
        S_DEC_READ,
        S_CHECK,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [FRAME-1:0]     r_frame;
    logic [KEY_BITS-1:0]  r_key;
    logic [127:0]         r_pt;
    logic [127:0]         r_exp;
    logic [127:0]         r_ct;
    logic [127:0]         r_ptout;
    logic                 r_pass_enc;
    logic                 r_pass_dec;
    logic                 r_err;
    logic                 w_load_last;
    logic                 w_wait_last;
    logic                 w_read_last;

    assign w_load_last = (r_cnt == LOAD_LAST);
    assign w_wait_last = (r_cnt == WAIT_LAST);
    assign w_read_last = (r_cnt == READ_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (start) w_next = S_ENC_LOAD;
            S_ENC_LOAD: if (w_load_last) w_next = S_ENC_WAIT;
            S_ENC_WAIT: begin
                if (enc_finished)     w_next = S_ENC_READ;
                else if (w_wait_last) w_next = S_DONE;
            end
            S_ENC_READ: if (w_read_last) w_next = S_DEC_LOAD;
            S_DEC_LOAD: if (w_load_last) w_next = S_DEC_WAIT;
            S_DEC_WAIT: begin
                if (dec_finished)     w_next = S_DEC_READ;
                else if (w_wait_last) w_next = S_DONE;
            end
            S_DEC_READ: if (w_read_last) w_next = S_CHECK;
            S_CHECK:    w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // The phase counter restarts on every state change, so it always holds the cycle index within the phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state || r_state == S_IDLE)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame    <= '0;
            r_key      <= '0;
            r_pt       <= '0;
            r_exp      <= '0;
            r_ct       <= '0;
            r_ptout    <= '0;
            r_pass_enc <= 1'b0;
            r_pass_dec <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pt       <= plaintext;
                        r_key      <= key;
                        r_exp      <= expected_ct;
                        r_frame    <= {key, plaintext};
                        r_ct       <= '0;
                        r_ptout    <= '0;
                        r_pass_enc <= 1'b0;
                        r_pass_dec <= 1'b0;
                        r_err      <= 1'b0;
                    end
                end
                S_ENC_LOAD, S_DEC_LOAD: r_frame <= r_frame >> 1;
                S_ENC_WAIT: if (!enc_finished && w_wait_last) r_err <= 1'b1;
                S_DEC_WAIT: if (!dec_finished && w_wait_last) r_err <= 1'b1;
                S_ENC_READ: begin
                    r_ct[r_cnt[6:0]] <= enc_dout;
                    // Last ciphertext bit arrives this cycle, so splice it straight into the decrypt frame.
                    if (w_read_last)
                        r_frame <= {r_key, enc_dout, r_ct[126:0]};
                end
                S_DEC_READ: r_ptout[r_cnt[6:0]] <= dec_dout;
                S_CHECK: begin
                    r_pass_enc <= (r_ct == r_exp);
                    r_pass_dec <= (r_ptout == r_pt);
                end
                default: ;
            endcase
        end
    end

    assign enc_cs      = (r_state == S_ENC_LOAD) || (r_state == S_ENC_READ);
    assign dec_cs      = (r_state == S_DEC_LOAD) || (r_state == S_DEC_READ);
    assign enc_din     = (r_state == S_ENC_LOAD) && r_frame[0];
    assign dec_din     = (r_state == S_DEC_LOAD) && r_frame[0];
    assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done        = (r_state == S_DONE);
    assign pass_enc    = r_pass_enc;
    assign pass_dec    = r_pass_dec;
    assign err_timeout = r_err;
    assign ct_out      = r_ct;
    assign pt_out      = r_ptout;

endmodule

// File: doc/aes_serial_selftest.md
Name: aes_serial_selftest

Overview:
- Parametrised self-test sequencer for the serial AES cores (Encrypt/Decrypt, any of AES-128/192/256).
- Loads plaintext+key into the encrypt core over the one-bit serial link and reads the ciphertext back. Loads ciphertext+key into the decrypt core and reads the recovered text back.
- Checks both results against supplied expected values, with per-phase timeout and sticky pass/fail status.
- Sits between a top-level test harness and the two core instances. Replaces fixed-vector, fixed-key-size hard-wired test wrappers.

Parameters:
- NK, 8, key length in 32-bit words; only 4, 6 or 8 are legal (elaboration error otherwise). KEY_BITS = 32*NK.
- TIMEOUT, 4096, max cycles spent waiting for a core's finished before aborting.
- CNT_W, 13, width of bit/wait counters; must hold max(128+KEY_BITS, TIMEOUT).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- start  in  1  one-cycle request to run a test; sampled only in IDLE.
- plaintext  in  128  test input; bit 0 sent first.
- key  in  KEY_BITS  cipher key; bit 0 sent first.
- expected_ct  in  128  expected ciphertext.
- enc_cs, dec_cs  out  1  chip select to encrypt / decrypt core.
- enc_din, dec_din  out  1  serial data to core.
- enc_dout, dec_dout  in  1  serial data from core.
- enc_finished, dec_finished  in  1  core done strobe/level.
- busy  out  1  high from cycle after accepted start until DONE.
- done  out  1  one-cycle pulse at end of run.
- pass_enc  out  1  captured ciphertext == expected_ct.
- pass_dec  out  1  recovered text == plaintext.
- err_timeout  out  1  a wait phase hit TIMEOUT.
- ct_out  out  128  ciphertext captured from encrypt core.
- pt_out  out  128  text captured from decrypt core.

Behaviour:
- Reset (rst=0, any state): state=IDLE. All cs, din, busy, done, pass_*, err_timeout = 0. ct_out and pt_out = 0. Counters = 0. Takes effect immediately, mid-frame included; cores see cs drop at once.
- FRAME = 128+KEY_BITS.
- IDLE: start=1 latches plaintext, key and expected_ct into internal registers (inputs may change afterwards). Clears pass_*, err_timeout, ct_out, pt_out. Sets busy=1 and goes to ENC_LOAD next cycle. start while busy is ignored.
- ENC_LOAD: enc_cs=1 for exactly FRAME cycles. In load cycle i, enc_din = latched plaintext[i] for i<128, else key[i-128]. After cycle FRAME-1 go to ENC_WAIT; enc_cs=0.
- ENC_WAIT: enc_cs=0 and the wait counter increments each cycle.
  - enc_finished=1 → ENC_READ next cycle.
  - Counter reaching TIMEOUT with finished still low → err_timeout=1, go to DONE.
  - finished and timeout in the same cycle: finished wins.
- ENC_READ: enc_cs=1 for 128 cycles. In read cycle j, ct_out[j] <= enc_dout. Then DEC_LOAD.
- DEC_LOAD: same as ENC_LOAD on the dec_* signals, with ct_out in place of plaintext.
- DEC_WAIT, DEC_READ: same as the encrypt phases. Read cycle j sets pt_out[j] <= dec_dout.
- CHECK (1 cycle): pass_enc <= (ct_out==expected_ct); pass_dec <= (pt_out==latched plaintext).
- DONE (1 cycle): done=1, busy=0, then IDLE. On the timeout path pass_enc=pass_dec=0.
- pass_*, err_timeout, ct_out and pt_out hold until the next accepted start or reset.
- Only one cs is ever high at a time.
- Latency with zero core wait and finished seen in the first wait cycle:
  - start to done = 2*(FRAME+128+1)+3 cycles.
  - NK=8: 1029.

Test Plan:
- NK=8, key 000102…1f, pt 00112233445566778899aabbccddeeff, expected 8ea2b7ca516745bfeafc49904b496089, behavioural cores → ct_out=expected, pt_out=pt, pass_enc=pass_dec=1, err_timeout=0, single done pulse.
- NK=4, key 000102…0f, same pt, expected 69c4e0d86a7b0430d8cdb78070b4c55a → both pass. Repeat NK=6 with key 000102…17 and expected dda97ca4864cdfe06eaf70a0ec0d7191 → both pass.
- NK=8 run with expected_ct off by one bit → pass_enc=0, pass_dec=1.
- Encrypt core model never asserts finished, TIMEOUT=64 → err_timeout=1 at wait cycle 64, both pass=0, dec_cs never asserted, done pulses.
- Reset asserted in mid ENC_LOAD (bit 200) → all outputs 0 immediately. A fresh start afterwards completes with both pass=1.
- start pulsed repeatedly during busy → ignored; exactly one done per accepted start. Cycle count start→done equals formula plus actual core wait cycles.
